osc_freq_counter: RTL

Measures the frequency of the on-chip ring oscillator by counting its rising edges over a fixed window of system clock cycles. It sits directly downstream of the oscillator's frequency divider. It takes one divided oscillator tap (normally the ÷8 output) as an asynchronous input and presents a latched edge count to the digital pins or to a readout block. It supports single-shot and continuous measurement.

---
 rtl/osc_pkg.sv | 13 +
 rtl/osc_freq_counter_if.sv | 14 +
 rtl/osc_edge_sync.sv | 32 +++
 rtl/osc_freq_counter.sv | 100 ++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the ring-oscillator frequency counter and its readout.
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } osc_state_e;

    localparam int OSC_COUNT_W     = 16;
    localparam int OSC_GATE_CYCLES = 1024;

endpackage

// File: rtl/osc_freq_counter_if.sv
// Control/result bundle between the frequency counter and whoever drives it.
interface osc_freq_counter_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic               cont;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (output start, cont, input busy, done, count, overflow);
    modport slave  (input start, cont, output busy, done, count, overflow);
endinterface

// File: rtl/osc_edge_sync.sv
// Synchronizes an asynchronous oscillator tap into clk and flags its rising edges.
// The edge output is named edge_det because "edge" is a reserved word.
module osc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_det
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the tap through the synchronizer; prev holds the last synchronized value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/osc_freq_counter.sv
// Counts rising edges of a divided oscillator tap over a fixed clk gate window.
module osc_freq_counter
    import osc_pkg::*;
#(
    parameter int GATE_CYCLES = OSC_GATE_CYCLES,
    parameter int COUNT_W     = OSC_COUNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    osc_freq_counter_if.slave     bus
);
    localparam int                GCW       = $clog2(GATE_CYCLES);
    localparam logic [GCW-1:0]    GATE_LAST = GCW'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] ACC_MAX  = '1;

    osc_state_e         state_q, state_d;
    logic [GCW-1:0]     gate_q, gate_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               osc_edge;

    osc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (osc_in),
        .edge_det (osc_edge)
    );

    // Gate FSM, gate counter and saturating edge accumulator. The result is
    // loaded on the way into DONE so it is visible together with done.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start || bus.cont) begin
                    state_d = GATE;
                    gate_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            GATE: begin
                gate_d = gate_q + 1'b1;
                if (osc_edge) begin
                    if (acc_q == ACC_MAX) sat_d = 1'b1;
                    else                  acc_d = acc_q + 1'b1;
                end
                if (gate_q == GATE_LAST) begin
                    state_d = DONE;
                    count_d = acc_d;
                    ovf_d   = sat_d;
                end
            end
            DONE: begin
                if (bus.cont) begin
                    state_d = GATE;
                    gate_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any gate in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == GATE);
    assign bus.done     = (state_q == DONE);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule
